// File: rtl/wakeup_cam_init_if.sv
// Dispatch-side bundle between the partition config controller, the init sequencer and the wakeup CAM.
// With WAKEUP_INIT_PERF_EN defined the bundle also carries the init write-cycle counter.
interface wakeup_cam_init_if #(
    parameter int NUM_PARTS = 4,
    parameter int INDEX     = 4,
    parameter int WIDTH     = 8
);
    logic [NUM_PARTS-1:0] part_req;
    logic                 force_init;
    logic [INDEX-1:0]     cam_wr_addr;
    logic [WIDTH-1:0]     cam_wr_data;
    logic                 cam_we;
    logic [NUM_PARTS-1:0] part_active;
    logic                 ram_ready;
    logic                 dispatch_stall;
`ifdef WAKEUP_INIT_PERF_EN
    logic [15:0]          init_cycle_cnt;
`endif

`ifdef WAKEUP_INIT_PERF_EN
    modport master (output part_req, force_init,
                    input  cam_wr_addr, cam_wr_data, cam_we, part_active,
                           ram_ready, dispatch_stall, init_cycle_cnt);
    modport slave  (input  part_req, force_init,
                    output cam_wr_addr, cam_wr_data, cam_we, part_active,
                           ram_ready, dispatch_stall, init_cycle_cnt);
`else
    modport master (output part_req, force_init,
                    input  cam_wr_addr, cam_wr_data, cam_we, part_active,
                           ram_ready, dispatch_stall);
    modport slave  (input  part_req, force_init,
                    output cam_wr_addr, cam_wr_data, cam_we, part_active,
                           ram_ready, dispatch_stall);
`endif
endinterface

// File: rtl/wakeup_cam_init_ctrl.sv
// Wakeup-CAM partition init sequencer: writes RESET_VAL through every entry of newly activated partitions.
// Optional WAKEUP_INIT_PERF_EN adds a saturating count of init write cycles.
//
//   state | meaning
//   IDLE  | watching for newly requested partitions, applying deactivations
//   INIT  | walking pending partitions lowest-first, one entry per cycle
module wakeup_cam_init_ctrl #(
    parameter int               DEPTH         = 16,
    parameter int               INDEX         = 4,
    parameter int               WIDTH         = 8,
    parameter int               NUM_PARTS     = 4,
    parameter int               NUM_PARTS_LOG = 2,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
    input logic               clk,
    input logic               reset,
    wakeup_cam_init_if.slave  bus
);
    localparam int CNT_W = INDEX - NUM_PARTS_LOG;
    localparam int PER   = DEPTH / NUM_PARTS;

    typedef enum logic {IDLE, INIT} state_t;

    state_t                   state;
    logic [NUM_PARTS-1:0]     applied;
    logic [NUM_PARTS-1:0]     pending;
    logic [NUM_PARTS_LOG-1:0] part_idx;
    logic [CNT_W-1:0]         cnt;
    logic                     ram_ready_q;

    logic [NUM_PARTS-1:0]     newly;
    logic [NUM_PARTS-1:0]     pend_next;
    logic                     last_entry;

    function automatic logic [NUM_PARTS_LOG-1:0] lowest(input logic [NUM_PARTS-1:0] m);
        lowest = '0;
        for (int i = NUM_PARTS - 1; i >= 0; i--) begin
            if (m[i]) lowest = NUM_PARTS_LOG'(i);
        end
    endfunction

    always_comb begin
        newly      = bus.force_init ? bus.part_req : (bus.part_req & ~applied);
        last_entry = (cnt == CNT_W'(PER - 1));
        pend_next  = pending & ~(NUM_PARTS'(1) << part_idx);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            applied     <= '0;
            pending     <= '0;
            part_idx    <= '0;
            cnt         <= '0;
            ram_ready_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // force re-init clears the applied mask so every requested partition is rewritten
                    applied <= bus.force_init ? '0 : (applied & bus.part_req);
                    if (newly != '0) begin
                        pending     <= newly;
                        part_idx    <= lowest(newly);
                        cnt         <= '0;
                        state       <= INIT;
                        ram_ready_q <= 1'b0;
                    end else begin
                        ram_ready_q <= 1'b1;
                    end
                end
                INIT: begin
                    if (last_entry) begin
                        cnt               <= '0;
                        applied[part_idx] <= 1'b1;
                        pending           <= pend_next;
                        if (pend_next != '0) begin
                            part_idx    <= lowest(pend_next);
                            ram_ready_q <= 1'b0;
                        end else begin
                            state       <= IDLE;
                            ram_ready_q <= 1'b1;
                        end
                    end else begin
                        cnt         <= cnt + 1'b1;
                        ram_ready_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cam_we         = (state == INIT);
    assign bus.cam_wr_addr    = {part_idx, cnt};
    assign bus.cam_wr_data    = RESET_VAL;
    assign bus.part_active    = applied;
    assign bus.ram_ready      = ram_ready_q;
    // stall is combinational so dispatch is already blocked in the detection cycle and during reset
    assign bus.dispatch_stall = ~reset | (state == INIT) | ((state == IDLE) & (newly != '0));

`ifdef WAKEUP_INIT_PERF_EN
    logic [15:0] perf_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_cnt <= '0;
        end else if ((state == INIT) && (perf_cnt != 16'hFFFF)) begin
            perf_cnt <= perf_cnt + 16'd1;
        end
    end

    assign bus.init_cycle_cnt = perf_cnt;
`endif
endmodule

// File: tb/tb_wakeup_cam_init_ctrl.sv
// Self-checking bench for wakeup_cam_init_ctrl: vector table, corner sequences and random traffic vs a queue model.
module tb_wakeup_cam_init_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wakeup_cam_init_if bus ();

    wakeup_cam_init_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int  addr;
        int  part;
        bit  last;
    } wr_t;

    typedef struct {
        logic [3:0] req;
        logic       frc;
        int         cycles;
        int         exp_writes;
        logic [3:0] exp_mask;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    int         writes = 0;
    int         wlog[$];
    wr_t        q[$];
    logic [3:0] m_applied;
    logic       m_rdy;
    int         m_perf;
    vec_t       vecs[7];

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_applied = 4'b0000;
        m_rdy     = 1'b0;
        m_perf    = 0;
        q.delete();
    endfunction

    // called at posedge+1; compares this cycle, advances the model across the next edge
    task automatic step(input logic [3:0] req, input logic frc);
        logic [3:0] n;
        bit         busy;
        wr_t        e;
        bus.part_req   = req;
        bus.force_init = frc;
        #1;
        busy = (q.size() != 0);
        n    = frc ? req : (req & ~m_applied);
        check("cam_we", int'(bus.cam_we), int'(busy));
        if (busy) check("cam_wr_addr", int'(bus.cam_wr_addr), q[0].addr);
        check("cam_wr_data", int'(bus.cam_wr_data), 0);
        check("part_active", int'(bus.part_active), int'(m_applied));
        check("ram_ready", int'(bus.ram_ready), int'(m_rdy));
        check("dispatch_stall", int'(bus.dispatch_stall), int'(busy || (n != 0)));
`ifdef WAKEUP_INIT_PERF_EN
        check("init_cycle_cnt", int'(bus.init_cycle_cnt), (m_perf > 65535) ? 65535 : m_perf);
`endif
        if (bus.cam_we) begin
            writes++;
            wlog.push_back(int'(bus.cam_wr_addr));
        end
        @(posedge clk);
        if (busy) begin
            e = q.pop_front();
            m_perf++;
            if (e.last) m_applied[e.part] = 1'b1;
        end else begin
            m_applied = frc ? 4'b0000 : (m_applied & req);
            for (int p = 0; p < 4; p++) begin
                if (n[p]) begin
                    for (int k = 0; k < 4; k++) q.push_back('{p * 4 + k, p, (k == 3)});
                end
            end
        end
        m_rdy = (q.size() == 0);
        #1;
    endtask

    // asserts reset away from the clock edge and checks outputs settle without an edge
    task automatic do_reset(input logic [3:0] req);
        bus.part_req   = req;
        bus.force_init = 1'b0;
        reset          = 1'b0;
        #1;
        check("rst_cam_we", int'(bus.cam_we), 0);
        check("rst_cam_wr_addr", int'(bus.cam_wr_addr), 0);
        check("rst_cam_wr_data", int'(bus.cam_wr_data), 0);
        check("rst_part_active", int'(bus.part_active), 0);
        check("rst_ram_ready", int'(bus.ram_ready), 0);
        check("rst_dispatch_stall", int'(bus.dispatch_stall), 1);
`ifdef WAKEUP_INIT_PERF_EN
        check("rst_init_cycle_cnt", int'(bus.init_cycle_cnt), 0);
`endif
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int w0;
        logic [3:0] rreq;
        vecs[0] = '{4'b0001, 1'b0, 8,  4,  4'b0001};
        vecs[1] = '{4'b1011, 1'b0, 12, 8,  4'b1011};
        vecs[2] = '{4'b0001, 1'b0, 3,  0,  4'b0001};
        vecs[3] = '{4'b0101, 1'b0, 8,  4,  4'b0101};
        vecs[4] = '{4'b0101, 1'b1, 12, 8,  4'b0101};
        vecs[5] = '{4'b0000, 1'b0, 3,  0,  4'b0000};
        vecs[6] = '{4'b1111, 1'b0, 20, 16, 4'b1111};

        reset          = 1'b1;
        bus.part_req   = 4'b0001;
        bus.force_init = 1'b0;
        #2;
        do_reset(4'b0001);

        for (int i = 0; i < 7; i++) begin
            w0 = writes;
            wlog.delete();
            for (int c = 0; c < vecs[i].cycles; c++)
                step(vecs[i].req, (c == 0) ? vecs[i].frc : 1'b0);
            check($sformatf("vec%0d_writes", i), writes - w0, vecs[i].exp_writes);
            check($sformatf("vec%0d_mask", i), int'(bus.part_active), int'(vecs[i].exp_mask));
            if (i == 0)
                for (int k = 0; k < 4; k++) check("vec0_addr", wlog[k], k);
            if (i == 1)
                for (int k = 0; k < 8; k++) check("vec1_addr", wlog[k], (k < 4) ? 4 + k : 8 + k);
            if (i == 4)
                for (int k = 0; k < 8; k++) check("vec4_addr", wlog[k], (k < 4) ? k : 4 + k);
        end

        // activation raised mid-walk waits for IDLE, then runs one cycle after it
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        w0 = writes;
        wlog.delete();
        step(4'b0010, 1'b0);
        step(4'b0010, 1'b0);
        for (int c = 0; c < 14; c++) step(4'b0110, 1'b0);
        check("late_req_writes", writes - w0, 8);
        for (int k = 0; k < 8; k++) check("late_req_addr", wlog[k], 4 + k);
        check("late_req_mask", int'(bus.part_active), 4'b0110);

        // reset after two writes discards the partial walk
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0010, 1'b0);
        step(4'b0010, 1'b0);
        step(4'b0010, 1'b0);
        do_reset(4'b0010);
        w0 = writes;
        wlog.delete();
        for (int c = 0; c < 8; c++) step(4'b0010, 1'b0);
        check("rst_mid_writes", writes - w0, 4);
        for (int k = 0; k < 4; k++) check("rst_mid_addr", wlog[k], 4 + k);
        check("rst_mid_mask", int'(bus.part_active), 4'b0010);

        rreq = 4'b0000;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 7) == 0) rreq = 4'($urandom_range(0, 15));
            step(rreq, ($urandom_range(0, 19) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
